// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad column scanner with debounced press/release and a one-deep event register
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] kpr,
    output logic [3:0] kpc,
    output logic       kphit,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overflow
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       sync1;
    logic [3:0]       kprs;
    logic [DIV_W-1:0] div;
    logic [DB_W-1:0]  cnt;
    logic [3:0]       row_pat;
    logic [1:0]       row_idx;
    logic [1:0]       col_idx;

    logic row_single;
    logic div_tc;
    logic match;
    logic released;
    logic cnt_last;

    logic latch;
    logic rotate;
    logic cnt_clr;
    logic cnt_inc;
    logic event_issue;

    function automatic logic [1:0] low_idx(input logic [3:0] p);
        case (p)
            4'b1110: low_idx = 2'd0;
            4'b1101: low_idx = 2'd1;
            4'b1011: low_idx = 2'd2;
            4'b0111: low_idx = 2'd3;
            default: low_idx = 2'd0;
        endcase
    endfunction

    // kpr is driven straight from the keypad switches, so it is resynchronised first
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= 4'b1111;
            kprs  <= 4'b1111;
        end else begin
            sync1 <= kpr;
            kprs  <= sync1;
        end
    end

    always_comb begin
        case (kprs)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: row_single = 1'b1;
            default:                            row_single = 1'b0;
        endcase
    end

    assign div_tc   = (div == DIV_LAST);
    assign match    = (kprs == row_pat);
    assign released = (kprs == 4'b1111);
    assign cnt_last = (cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= SCAN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SCAN: begin
                if (div_tc && row_single) begin
                    state_next = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (!match) begin
                    state_next = SCAN;
                end else if (cnt_last) begin
                    state_next = HELD;
                end
            end
            HELD: begin
                if (released) begin
                    state_next = REL_DB;
                end
            end
            REL_DB: begin
                if (!released) begin
                    state_next = HELD;
                end else if (cnt_last) begin
                    state_next = SCAN;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    always_comb begin
        latch       = 1'b0;
        rotate      = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        event_issue = 1'b0;
        kphit       = 1'b0;
        case (state)
            SCAN: begin
                if (div_tc) begin
                    if (row_single) begin
                        latch   = 1'b1;
                        cnt_clr = 1'b1;
                    end else begin
                        rotate = 1'b1;
                    end
                end
            end
            PRESS_DB: begin
                if (!match) begin
                    rotate = 1'b1;
                end else if (cnt_last) begin
                    event_issue = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            HELD: begin
                kphit   = 1'b1;
                cnt_clr = released;
            end
            REL_DB: begin
                kphit = 1'b1;
                if (released) begin
                    if (cnt_last) begin
                        rotate = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Divider only runs while scanning, so every return to SCAN starts a fresh column period
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div <= '0;
        end else if (state == SCAN && !div_tc) begin
            div <= div + DIV_W'(1);
        end else begin
            div <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            kpc <= 4'b1110;
        end else if (rotate) begin
            kpc <= {kpc[2:0], kpc[3]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + DB_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            row_pat <= 4'b1111;
            row_idx <= 2'd0;
            col_idx <= 2'd0;
        end else if (latch) begin
            row_pat <= kprs;
            row_idx <= low_idx(kprs);
            col_idx <= low_idx(kpc);
        end
    end

    // One-deep event register: a new event may replace one being consumed this cycle, otherwise it is dropped
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (event_issue && (!key_valid || key_ready)) begin
            key_code  <= {row_idx, col_idx};
            key_valid <= 1'b1;
        end else if (event_issue) begin
            overflow <= 1'b1;
        end else if (key_valid && key_ready) begin
            key_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - directed self-checking bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] kpr;
    logic [3:0] kpc;
    logic       kphit;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    logic       key_on;
    logic [3:0] key_col;
    logic [3:0] key_row;
    logic       force_en;
    logic [3:0] force_val;

    logic [3:0] col_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    keypad_scan_ctrl #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .kpr       (kpr),
        .kpc       (kpc),
        .kphit     (kphit),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Keypad matrix model: a held key pulls its row low only while its column is strobed
    always_comb begin
        if (force_en) begin
            kpr = force_val;
        end else if (key_on && kpc == key_col) begin
            kpr = key_row;
        end else begin
            kpr = 4'b1111;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_sig(input int sel, input logic val, input int limit, input string tag, output int n);
        logic s;
        for (n = 0; n < limit; n++) begin
            s = (sel == 0) ? key_valid : kphit;
            if (s == val) break;
            tick();
        end
        s = (sel == 0) ? key_valid : kphit;
        check(tag, s, val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int vcount;
        int hcount;
        int changes;
        logic [3:0] prev;

        reset_n   = 1'b0;
        key_ready = 1'b0;
        key_on    = 1'b0;
        force_en  = 1'b0;
        force_val = 4'b1111;
        key_col   = 4'b1101;
        key_row   = 4'b1011;
        repeat (3) tick();
        check("rst_kpc", kpc, 4'b1110);
        check("rst_kphit", kphit, 0);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_ovf", overflow, 0);

        // Idle scan: each column strobe held for 4 cycles
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            check("idle_kpc", kpc, col_pat[(k / 4) % 4]);
            check("idle_valid", key_valid, 0);
            tick();
        end

        // Clean press of row 2 / column 1
        key_ready = 1'b1;
        key_on    = 1'b1;
        wait_sig(0, 1'b1, 100, "t2_valid", n);
        check("t2_code", key_code, 4'b1001);
        check("t2_hit", kphit, 1);
        tick();
        check("t2_one_cycle", key_valid, 0);
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            vcount += key_valid;
        end
        check("t2_no_repeat", vcount, 0);
        check("t2_still_hit", kphit, 1);
        key_on = 1'b0;
        for (int j = 1; j <= 11; j++) begin
            tick();
            if (j == 10) check("t2_hit_before_rel", kphit, 1);
            if (j == 11) begin
                check("t2_hit_after_rel", kphit, 0);
                check("t2_kpc_adv", kpc, 4'b1011);
            end
        end

        // Bouncing press then stable
        vcount = 0;
        hcount = 0;
        for (int i = 0; i < 30; i++) begin
            key_on = ((i / 3) % 2 == 0);
            tick();
            vcount += key_valid;
            hcount += kphit;
        end
        check("t3_bounce_valid", vcount, 0);
        check("t3_bounce_hit", hcount, 0);
        key_on = 1'b1;
        wait_sig(0, 1'b1, 60, "t3_valid", n);
        check("t3_code", key_code, 4'b1001);
        check("t3_latency_min", n >= 10, 1);
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            vcount += key_valid;
        end
        check("t3_single_event", vcount, 0);
        key_on = 1'b0;
        wait_sig(1, 1'b0, 40, "t3_release", n);

        // Overflow: second press while first event is unconsumed
        key_ready = 1'b0;
        key_on    = 1'b1;
        wait_sig(0, 1'b1, 100, "t4_first", n);
        check("t4_first_code", key_code, 4'b1001);
        check("t4_no_ovf_yet", overflow, 0);
        key_on = 1'b0;
        wait_sig(1, 1'b0, 40, "t4_rel_a", n);
        key_col = 4'b1011;
        key_row = 4'b1110;
        key_on  = 1'b1;
        wait_sig(1, 1'b1, 100, "t4_second_hit", n);
        check("t4_valid_kept", key_valid, 1);
        check("t4_code_kept", key_code, 4'b1001);
        check("t4_ovf", overflow, 1);
        key_on = 1'b0;
        wait_sig(1, 1'b0, 40, "t4_rel_b", n);
        key_ready = 1'b1;
        tick();
        check("t4_pop_valid", key_valid, 0);
        check("t4_pop_ovf", overflow, 1);
        repeat (3) tick();
        check("t4_idle_ready_valid", key_valid, 0);
        check("t4_idle_ready_code", key_code, 4'b1001);
        key_ready = 1'b0;

        // Two rows low at once is treated as ghosting
        force_en  = 1'b1;
        force_val = 4'b1001;
        prev      = kpc;
        changes   = 0;
        vcount    = 0;
        hcount    = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (kpc != prev) changes++;
            prev = kpc;
            vcount += key_valid;
            hcount += kphit;
        end
        check("t5_rotations", changes, 6);
        check("t5_valid", vcount, 0);
        check("t5_hit", hcount, 0);
        force_en = 1'b0;
        repeat (4) tick();

        // Reset while HELD with an unconsumed event
        key_col = 4'b1101;
        key_row = 4'b1011;
        key_on  = 1'b1;
        wait_sig(1, 1'b1, 100, "t6_held", n);
        check("t6_valid_pre", key_valid, 1);
        check("t6_ovf_pre", overflow, 1);
        repeat (2) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        key_on  = 1'b0;
        check("t6_kpc", kpc, 4'b1110);
        check("t6_hit", kphit, 0);
        check("t6_valid", key_valid, 0);
        check("t6_ovf", overflow, 0);
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            vcount += key_valid;
        end
        check("t6_abandon", vcount, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000: clock cycles each column strobe is held.
REQ-002 The block SHALL have parameter DEBOUNCE_CNT, default 20000: consecutive stable cycles required for press/release acceptance.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port kpr, input, 4 bits: keypad row sense, active-low and asynchronous to clk.
REQ-006 The block SHALL have port kpc, output, 4 bits: keypad column strobe, one-hot-low.
REQ-007 The block SHALL have port kphit, output, 1 bit: a debounced key is currently held.
REQ-008 The block SHALL have port key_code, output, 4 bits: accepted key, encoded {row_idx[1:0], col_idx[1:0]}.
REQ-009 The block SHALL have port key_valid, output, 1 bit: key_code holds an unconsumed event.
REQ-010 The block SHALL have port key_ready, input, 1 bit: the consumer accepts the event.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky flag, an event was dropped.

Function
REQ-012 kpr SHALL pass through a 2-flop synchronizer, and every use of "kpr" below SHALL mean the synchronized value (kprs).
REQ-013 Index mapping SHALL be: kpc/kpr pattern 1110 -> idx 0, 1101 -> 1, 1011 -> 2, 0111 -> 3.
REQ-014 The FSM SHALL have states SCAN, PRESS_DB, HELD and REL_DB.
REQ-015 In SCAN, a divider SHALL count 0..SCAN_DIV-1, and on terminal count kpc SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110 (wrap).
REQ-016 In SCAN, on the terminal-count cycle, if kprs has exactly one zero the block SHALL latch col_idx (current kpc) and row_idx, hold kpc frozen, clear the debounce counter, and enter PRESS_DB.
REQ-017 In SCAN, kprs equal to 1111 or with two or more zeros (ghosting) SHALL be ignored: no latch, rotation continues.
REQ-018 In PRESS_DB, the debounce counter SHALL increment each cycle kprs equals the latched row pattern.
REQ-019 In PRESS_DB, any cycle with kprs different from the latched pattern SHALL return the FSM to SCAN, with kpc advancing to the next column and the divider cleared.
REQ-020 In PRESS_DB, when the counter reaches DEBOUNCE_CNT-1 with a matching pattern, the FSM SHALL enter HELD, with kphit=1 from the next cycle, and SHALL issue an event.
REQ-021 Event issue with key_valid=0 (or key_valid=1 and key_ready=1 in the same cycle) SHALL load key_code and set key_valid=1 on the next cycle.
REQ-022 Event issue with key_valid=1 and key_ready=0 SHALL leave key_code unchanged, drop the new event, and set overflow=1.
REQ-023 Handshake: key_valid and key_code SHALL remain stable until a cycle with key_valid=1 and key_ready=1; key_valid SHALL clear the next cycle unless REQ-021 reloads it.
REQ-024 key_ready while key_valid=0 SHALL have no effect.
REQ-025 In HELD, kpc SHALL stay frozen; when kprs equals 1111 the FSM SHALL clear the counter and enter REL_DB.
REQ-026 In REL_DB, kprs not equal to 1111 SHALL return the FSM to HELD, and DEBOUNCE_CNT consecutive 1111 cycles SHALL enter SCAN with kphit=0, kpc advancing to the next column, and the divider cleared.
REQ-027 Auto-repeat SHALL NOT exist: one event per debounced press.
REQ-028 overflow SHALL clear only on reset.
REQ-029 The debounce counter width SHALL be $clog2(DEBOUNCE_CNT) with no wrap, and the divider width SHALL be $clog2(SCAN_DIV).

Reset
REQ-030 While reset_n=0 at a clk edge, the block SHALL force: state=SCAN, kpc=1110, divider=0, counter=0, kphit=0, key_code=0, key_valid=0, overflow=0, and synchronizer flops=1111.
REQ-031 Reset asserted in any state, mid-debounce or mid-handshake, SHALL abandon the pending event with no event emitted.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-032 The bench SHALL cover: idle with kpr=1111 -> kpc sequence 1110,1101,1011,0111,1110 each held 4 cycles; key_valid=0 throughout.
REQ-033 The bench SHALL cover: kpr=1011 whenever kpc=1101, held 20 cycles, key_ready=1 -> key_code=4'b1001 with key_valid for exactly 1 cycle; kphit=1 until 8 cycles after kpr returns to 1111.
REQ-034 The bench SHALL cover: a press bouncing 1011/1111 every 3 cycles for 30 cycles, then stable -> exactly one event after 8 stable cycles; no event during the bounce.
REQ-035 The bench SHALL cover: key_ready=0 with two distinct presses -> key_code keeps the first press and overflow=1; key_ready pulse -> key_valid=0 the next cycle, overflow stays 1.
REQ-036 The bench SHALL cover: kpr=1001 (two rows) during a scan -> no latch, kpc continues rotating, no event.
REQ-037 The bench SHALL cover: reset_n=0 for 1 cycle during HELD with key_valid=1 -> next cycle kpc=1110, kphit=0, key_valid=0, overflow=0.
